// File: rtl/inport_ctl.sv
// inport_ctl: router input port. Buffers incoming flits in a small FIFO,
// computes the XY route for each packet head and runs the request/grant
// handshake with the selected output controller.
module inport_ctl #(
  parameter int PORTID = 0,
  parameter int MYX    = 0,
  parameter int MYY    = 0,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic [35:0] idata,
  input  logic        ivalid,
  output logic        irdy,
  output logic [2:0]  port,
  output logic        req,
  input  logic        grt,
  output logic [35:0] odata,
  output logic        ovalid,
  input  logic        ordy,
  output logic        err_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] MY_X = 4'(MYX);
  localparam logic [3:0] MY_Y = 4'(MYY);

  localparam logic [1:0] FT_SINGLE = 2'b00;
  localparam logic [1:0] FT_TAIL   = 2'b11;

  // Catch a bad instantiation at elaboration; PORTID names the offending port.
  if (PORTID < 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
    $error("inport_ctl port %0d: DEPTH must be a power of two >= 2", PORTID);
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  state_t         state_reg;
  logic [2:0]     port_reg;
  logic           err_drop_reg;

  logic [35:0]    mem [DEPTH];
  logic [AW:0]    wr_ptr_reg;
  logic [AW:0]    rd_ptr_reg;

  logic           empty;
  logic           full;
  logic           push;
  logic           pop;
  logic           fwd;
  logic           drop;
  logic [1:0]     head_type;
  logic           head_is_start;
  logic           head_is_last;
  logic [3:0]     head_dx;
  logic [3:0]     head_dy;
  logic [2:0]     route_port;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = ((wr_ptr_reg ^ rd_ptr_reg) == {1'b1, {AW{1'b0}}});

  assign odata     = mem[rd_ptr_reg[AW-1:0]];
  assign head_type = odata[35:34];
  assign head_dx   = odata[7:4];
  assign head_dy   = odata[3:0];

  // Single and head flits open a packet; body and tail (type bit 1 set) do not.
  assign head_is_start = !empty && !head_type[1];
  assign head_is_last  = (head_type == FT_SINGLE) || (head_type == FT_TAIL);

  assign irdy   = !full;
  assign push   = ivalid && !full;
  assign req    = (state_reg != ST_IDLE);
  assign ovalid = (state_reg == ST_XFER) && grt && !empty;
  assign fwd    = ovalid && ordy;
  // A body/tail at the head while idle has no packet to belong to.
  assign drop   = (state_reg == ST_IDLE) && !empty && head_type[1];
  assign pop    = fwd || drop;

  assign port     = port_reg;
  assign err_drop = err_drop_reg;

  // Dimension-ordered route: resolve X first, then Y, else deliver locally.
  always_comb begin
    route_port = 3'd0;
    if (head_dx > MY_X)      route_port = 3'd1;
    else if (head_dx < MY_X) route_port = 3'd2;
    else if (head_dy > MY_Y) route_port = 3'd3;
    else if (head_dy < MY_Y) route_port = 3'd4;
  end

  // FIFO storage write; contents are left unreset, only pointers matter.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= idata;
  end

  // FIFO pointer update; reset empties the buffer and discards any partial packet.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  // Packet FSM: port is latched only when a packet opens and holds until
  // its last flit leaves, so the output controller keeps the grant.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_reg    <= ST_IDLE;
      port_reg     <= 3'd0;
      err_drop_reg <= 1'b0;
    end else begin
      err_drop_reg <= drop;
      case (state_reg)
        ST_IDLE: begin
          if (head_is_start) begin
            state_reg <= ST_REQ;
            port_reg  <= route_port;
          end
        end
        ST_REQ: begin
          if (grt) state_reg <= ST_XFER;
        end
        ST_XFER: begin
          if (fwd && head_is_last) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inport_ctl.sv
// tb_inport_ctl: randomized and directed checks of inport_ctl against a
// queue-based packet model of the input port.
module tb_inport_ctl;

  localparam int DEPTH = 4;
  localparam int MYX   = 1;
  localparam int MYY   = 1;

  localparam logic [1:0] T_SINGLE = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_BODY   = 2'b10;
  localparam logic [1:0] T_TAIL   = 2'b11;

  logic        clk = 1'b0;
  logic        rst_;
  logic [35:0] idata;
  logic        ivalid;
  logic        irdy;
  logic [2:0]  port;
  logic        req;
  logic        grt;
  logic [35:0] odata;
  logic        ovalid;
  logic        ordy;
  logic        err_drop;

  inport_ctl #(.PORTID(2), .MYX(MYX), .MYY(MYY), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .irdy(irdy),
    .port(port), .req(req), .grt(grt), .odata(odata), .ovalid(ovalid),
    .ordy(ordy), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: buffered flits, packet open / granted flags.
  logic [35:0] m_q[$];
  bit          m_busy;
  bit          m_granted;
  bit          m_err;
  logic [2:0]  m_port;

  logic [35:0] txq[$];      // flits waiting to be offered upstream
  logic [35:0] exp_out[$];  // flits the model says leave the port
  logic [35:0] dut_out[$];  // flits observed leaving the port
  logic [6:0]  obs;
  logic [6:0]  exp;
  bit          ok;

  function automatic logic [35:0] mk(input logic [1:0] t, input int x, input int y);
    return {t, 26'($urandom), 4'(x), 4'(y)};
  endfunction

  function automatic logic [2:0] route(input logic [35:0] f);
    int dx = int'(f[7:4]);
    int dy = int'(f[3:0]);
    if (dx > MYX) return 3'd1;
    if (dx < MYX) return 3'd2;
    if (dy > MYY) return 3'd3;
    if (dy < MYY) return 3'd4;
    return 3'd0;
  endfunction

  // Expected {irdy, req, port, ovalid, err_drop} for the current cycle.
  function automatic logic [6:0] exp_vec();
    return {(m_q.size() < DEPTH), m_busy, m_port,
            (m_busy && m_granted && grt && (m_q.size() > 0)), m_err};
  endfunction

  task automatic reset_model();
    m_q.delete();
    txq.delete();
    m_busy    = 0;
    m_granted = 0;
    m_err     = 0;
    m_port    = 3'd0;
  endtask

  task automatic drive(input bit v, input bit g, input bit o);
    ivalid = v && (txq.size() > 0);
    idata  = (txq.size() > 0) ? txq[0] : 36'd0;
    grt    = g;
    ordy   = o;
    #1;
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic tick();
    bit         do_push  = ivalid && (m_q.size() < DEPTH);
    bit         nonempty = (m_q.size() > 0);
    logic [1:0] t        = nonempty ? m_q[0][35:34] : T_SINGLE;
    bit         n_err    = 0;
    if (ovalid && ordy) begin
      dut_out.push_back(odata);
      $display("cyc%0d flit out %h port %0d", cyc, odata, port);
    end
    if (!m_busy) begin
      if (nonempty) begin
        if (t == T_BODY || t == T_TAIL) begin
          void'(m_q.pop_front());
          n_err = 1;
        end else begin
          m_busy = 1;
          m_port = route(m_q[0]);
        end
      end
    end else if (!m_granted) begin
      if (grt) m_granted = 1;
    end else if (grt && nonempty && ordy) begin
      exp_out.push_back(m_q.pop_front());
      if (t == T_SINGLE || t == T_TAIL) begin
        m_busy    = 0;
        m_granted = 0;
      end
    end
    if (do_push) begin
      m_q.push_back(idata);
      void'(txq.pop_front());
    end
    m_err = n_err;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst_ = 1'b0; ivalid = 1'b0; idata = '0; grt = 1'b0; ordy = 1'b0;
    reset_model();
    #3;
    obs = {irdy, req, port, ovalid, err_drop}; n_cmp++;
    if (obs !== 7'b1_0_000_0_0) begin
      n_bad++; $display("FAIL reset outputs got %b want %b", obs, 7'b1_0_000_0_0);
    end
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  task automatic test_packet();
    logic [2:0] port_seen = 3'd7;
    int         nval = 0;
    txq = {mk(T_HEAD, 3, 1), mk(T_BODY, 0, 0), mk(T_TAIL, 0, 0)};
    for (int k = 0; k < 14; k++) begin
      drive(1, k >= 4, 1);
      obs = {irdy, req, port, ovalid, err_drop}; exp = exp_vec(); n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL packet cyc%0d outs got %b want %b", cyc, obs, exp); end
      if (m_q.size() > 0) begin
        n_cmp++;
        if (odata !== m_q[0]) begin n_bad++; $display("FAIL packet_odata cyc%0d got %h want %h", cyc, odata, m_q[0]); end
      end
      if (req && port_seen == 3'd7) port_seen = port;
      tick();
    end
    n_cmp++;
    if (port_seen !== 3'd1) begin n_bad++; $display("FAIL packet_port got %0d want 1", port_seen); end
    n_cmp++; ok = (dut_out.size() == 3) && (exp_out.size() == 3);
    foreach (exp_out[i]) if (ok && dut_out[i] !== exp_out[i]) ok = 0;
    if (!ok) begin n_bad++; $display("FAIL packet_stream got %0d flits want 3 in order", dut_out.size()); end
    dut_out.delete(); exp_out.delete();
    // Single flit to this router: local port, exactly one forwarding cycle.
    txq = {mk(T_SINGLE, 1, 1)};
    for (int k = 0; k < 6; k++) begin
      drive(1, 1, 1);
      obs = {irdy, req, port, ovalid, err_drop}; exp = exp_vec(); n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL single cyc%0d outs got %b want %b", cyc, obs, exp); end
      if (ovalid) nval++;
      tick();
    end
    n_cmp++;
    if (nval != 1 || req !== 1'b0 || dut_out.size() != 1) begin
      n_bad++; $display("FAIL single_done ovalid_cycles %0d req %b flits %0d want 1 0 1", nval, req, dut_out.size());
    end
    dut_out.delete(); exp_out.delete();
  endtask

  task automatic test_full();
    txq = {mk(T_HEAD, 0, 2), mk(T_BODY, 0, 0), mk(T_BODY, 0, 0), mk(T_BODY, 0, 0)};
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0);
      obs = {irdy, req, port, ovalid, err_drop}; exp = exp_vec(); n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL full_fill cyc%0d outs got %b want %b", cyc, obs, exp); end
      tick();
    end
    drive(0, 0, 0);
    n_cmp++;
    if (irdy !== 1'b0) begin n_bad++; $display("FAIL full_irdy got %b want 0", irdy); end
    for (int k = 0; k < 8; k++) txq.push_back(mk(T_BODY, 0, 0));
    txq.push_back(mk(T_TAIL, 0, 0));
    for (int k = 0; k < 24; k++) begin
      drive(1, 1, 1);
      obs = {irdy, req, port, ovalid, err_drop}; exp = exp_vec(); n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL full_stream cyc%0d outs got %b want %b", cyc, obs, exp); end
      if (m_q.size() > 0) begin
        n_cmp++;
        if (odata !== m_q[0]) begin n_bad++; $display("FAIL full_odata cyc%0d got %h want %h", cyc, odata, m_q[0]); end
      end
      tick();
    end
    n_cmp++; ok = (dut_out.size() == exp_out.size()) && (exp_out.size() == 13);
    foreach (exp_out[i]) if (ok && dut_out[i] !== exp_out[i]) ok = 0;
    if (!ok) begin n_bad++; $display("FAIL full_order got %0d flits want 13 in order", dut_out.size()); end
    dut_out.delete(); exp_out.delete();
  endtask

  task automatic test_stray();
    int ndrop = 0;
    bit req_seen = 0;
    txq = {mk(T_BODY, 0, 0), mk(T_TAIL, 0, 0)};
    for (int k = 0; k < 6; k++) begin
      drive(k == 0 || k == 3, 0, 1);
      obs = {irdy, req, port, ovalid, err_drop}; exp = exp_vec(); n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL stray cyc%0d outs got %b want %b", cyc, obs, exp); end
      if (err_drop) ndrop++;
      if (req) req_seen = 1;
      tick();
    end
    n_cmp++;
    if (ndrop != 2 || req_seen) begin
      n_bad++; $display("FAIL stray_summary drops %0d req_seen %b want 2 0", ndrop, req_seen);
    end
  endtask

  task automatic test_stall();
    bit req_gap = 0;
    bit port_chg = 0;
    logic [2:0] p0 = 3'd0;
    txq = {mk(T_HEAD, 1, 0)};
    for (int k = 0; k < 5; k++) txq.push_back(mk(T_BODY, 0, 0));
    txq.push_back(mk(T_TAIL, 0, 0));
    for (int k = 0; k < 32; k++) begin
      drive(1, (k % 3) != 1, (k % 2) == 0);
      obs = {irdy, req, port, ovalid, err_drop}; exp = exp_vec(); n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL stall cyc%0d outs got %b want %b", cyc, obs, exp); end
      if (k == 3) p0 = port;
      if (k >= 3 && exp_out.size() < 7) begin
        if (!req) req_gap = 1;
        if (port !== p0) port_chg = 1;
      end
      tick();
    end
    n_cmp++; ok = (dut_out.size() == 7) && (exp_out.size() == 7) && !req_gap && !port_chg && (p0 === 3'd4);
    foreach (exp_out[i]) if (ok && dut_out[i] !== exp_out[i]) ok = 0;
    if (!ok) begin
      n_bad++; $display("FAIL stall_summary flits %0d req_gap %b port_chg %b port %0d want 7 0 0 4", dut_out.size(), req_gap, port_chg, p0);
    end
    dut_out.delete(); exp_out.delete();
  endtask

  task automatic test_async_reset();
    txq = {mk(T_HEAD, 2, 2), mk(T_BODY, 0, 0), mk(T_BODY, 0, 0), mk(T_TAIL, 0, 0)};
    for (int k = 0; k < 6; k++) begin
      drive(1, 1, k == 4);
      obs = {irdy, req, port, ovalid, err_drop}; exp = exp_vec(); n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL areset_pre cyc%0d outs got %b want %b", cyc, obs, exp); end
      tick();
    end
    drive(0, 1, 0);
    n_cmp++;
    if (req !== 1'b1 || ovalid !== 1'b1) begin n_bad++; $display("FAIL areset_xfer req %b ovalid %b want 1 1", req, ovalid); end
    #2 rst_ = 1'b0;
    #1;
    obs = {irdy, req, port, ovalid, err_drop}; n_cmp++;
    if (obs !== 7'b1_0_000_0_0) begin n_bad++; $display("FAIL areset_now got %b want %b", obs, 7'b1_0_000_0_0); end
    reset_model();
    dut_out.delete(); exp_out.delete();
    @(negedge clk);
    rst_ = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 1);
      obs = {irdy, req, port, ovalid, err_drop}; exp = exp_vec(); n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL areset_post cyc%0d outs got %b want %b", cyc, obs, exp); end
      tick();
    end
    n_cmp++;
    if (dut_out.size() != 0) begin n_bad++; $display("FAIL areset_resume got %0d flits want 0", dut_out.size()); end
  endtask

  task automatic test_random();
    int guard = 0;
    for (int p = 0; p < 40; p++) begin
      int kind = $urandom_range(0, 9);
      if (kind == 0) txq.push_back(mk(T_BODY, 0, 0));
      else if (kind < 4) txq.push_back(mk(T_SINGLE, $urandom_range(0, 3), $urandom_range(0, 3)));
      else begin
        int nb = $urandom_range(0, 4);
        txq.push_back(mk(T_HEAD, $urandom_range(0, 3), $urandom_range(0, 3)));
        for (int b = 0; b < nb; b++) txq.push_back(mk($urandom_range(0, 4) == 0 ? T_HEAD : T_BODY, 0, 0));
        txq.push_back(mk(T_TAIL, 0, 0));
      end
    end
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
      obs = {irdy, req, port, ovalid, err_drop}; exp = exp_vec(); n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL random cyc%0d outs got %b want %b", cyc, obs, exp); end
      if (m_q.size() > 0) begin
        n_cmp++;
        if (odata !== m_q[0]) begin n_bad++; $display("FAIL random_odata cyc%0d got %h want %h", cyc, odata, m_q[0]); end
      end
      tick();
    end
    while ((txq.size() > 0 || m_q.size() > 0 || m_busy) && guard < 300) begin
      drive(1, 1, 1);
      obs = {irdy, req, port, ovalid, err_drop}; exp = exp_vec(); n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL drain cyc%0d outs got %b want %b", cyc, obs, exp); end
      tick();
      guard++;
    end
    n_cmp++;
    if (guard >= 300) begin n_bad++; $display("FAIL drain_timeout queued %0d want 0", m_q.size()); end
    n_cmp++; ok = (dut_out.size() == exp_out.size());
    foreach (exp_out[i]) if (ok && dut_out[i] !== exp_out[i]) ok = 0;
    if (!ok) begin n_bad++; $display("FAIL random_order got %0d flits want %0d in order", dut_out.size(), exp_out.size()); end
    dut_out.delete(); exp_out.delete();
  endtask

  initial begin
    test_reset();
    test_packet();
    test_full();
    test_stray();
    test_stall();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
